// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory line responder.
// The FSM state type, line and address widths, and default timing and depth values.
package mem_resp_pkg;

    localparam int LINE_W          = 128;
    localparam int ADDR_W          = 28;
    localparam int DEF_LATENCY     = 4;
    localparam int DEF_DEPTH_LOG2  = 6;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_READY = 2'd2
    } state_e;

endpackage

// File: rtl/mem_line_array.sv
// Line storage with one combinational read port and two write ports.
// The commit port is assigned last, so it wins over the init port when both target the same index.
module mem_line_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [LINE_W-1:0]     rd_data,
    input  logic                  commit_en,
    input  logic [DEPTH_LOG2-1:0] commit_addr,
    input  logic [LINE_W-1:0]     commit_data,
    input  logic                  init_en,
    input  logic [DEPTH_LOG2-1:0] init_addr,
    input  logic [LINE_W-1:0]     init_data
);

    logic [LINE_W-1:0] mem_q [2**DEPTH_LOG2];

    // Line writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (init_en) begin
            mem_q[init_addr] <= init_data;
        end
        if (commit_en) begin
            mem_q[commit_addr] <= commit_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mem_line_responder.sv
// Fixed-latency line read/write responder for a cache miss path.
// Accepts a request in IDLE, waits LATENCY edges, then pulses mem_ready for one cycle.
module mem_line_responder
    import mem_resp_pkg::*;
#(
    parameter int LATENCY    = DEF_LATENCY,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  proc_reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [LINE_W-1:0]     mem_wdata,
    output logic [LINE_W-1:0]     mem_rdata,
    output logic                  mem_ready,
    input  logic                  init_en,
    input  logic [DEPTH_LOG2-1:0] init_addr,
    input  logic [LINE_W-1:0]     init_data,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  op_write_q, op_write_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [LINE_W-1:0]     wdata_q, wdata_d;
    logic [LINE_W-1:0]     rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;

    logic [LINE_W-1:0]     rd_line_s;
    logic                  commit_en_s;
    logic                  unused_addr_s;

    // Upper address bits alias onto the stored lines by design.
    assign unused_addr_s = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

    assign commit_en_s = (state_q == ST_READY) && op_write_q && !proc_reset;

    mem_line_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk         (clk),
        .rd_addr     (idx_d),
        .rd_data     (rd_line_s),
        .commit_en   (commit_en_s),
        .commit_addr (idx_q),
        .commit_data (wdata_q),
        .init_en     (init_en),
        .init_addr   (init_addr),
        .init_data   (init_data)
    );

    // Next-state, transaction latch and read-data capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    op_write_d = mem_write;
                    idx_d      = mem_addr[DEPTH_LOG2-1:0];
                    wdata_d    = mem_wdata;
                    cnt_d      = CNT_LOAD;
                    state_d    = (LATENCY == 1) ? ST_READY : ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_READY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Capture on entry to READY; forward a same-edge init so rdata matches the line held during READY.
        if ((state_d == ST_READY) && (state_q != ST_READY) && !op_write_d) begin
            if (init_en && (init_addr == idx_d)) begin
                rdata_d = init_data;
            end else begin
                rdata_d = rd_line_s;
            end
        end else begin
            rdata_d = rdata_q;
        end
        ready_d = (state_d == ST_READY);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            op_write_q <= 1'b0;
            idx_q      <= {DEPTH_LOG2{1'b0}};
            wdata_q    <= {LINE_W{1'b0}};
            rdata_q    <= {LINE_W{1'b0}};
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed scoreboard bench for mem_line_responder: default LATENCY=4 instance (A)
// and a LATENCY=1 instance (B) for back-to-back held requests.
module tb_mem_line_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         proc_reset;

    logic         a_read, a_write, a_ready, a_busy, a_init_en;
    logic [27:0]  a_addr;
    logic [127:0] a_wdata, a_rdata, a_init_data;
    logic [5:0]   a_init_addr;

    logic         b_read, b_write, b_ready, b_busy, b_init_en;
    logic [27:0]  b_addr;
    logic [127:0] b_wdata, b_rdata, b_init_data;
    logic [5:0]   b_init_addr;

    int checks   = 0;
    int failures = 0;
    logic [127:0] sb_q [$];

    mem_line_responder #(.LATENCY(4), .DEPTH_LOG2(6)) dut_a (
        .clk(clk), .proc_reset(proc_reset), .mem_read(a_read), .mem_write(a_write),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_rdata), .mem_ready(a_ready),
        .init_en(a_init_en), .init_addr(a_init_addr), .init_data(a_init_data), .busy(a_busy)
    );

    mem_line_responder #(.LATENCY(1), .DEPTH_LOG2(6)) dut_b (
        .clk(clk), .proc_reset(proc_reset), .mem_read(b_read), .mem_write(b_write),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_ready(b_ready),
        .init_en(b_init_en), .init_addr(b_init_addr), .init_data(b_init_data), .busy(b_busy)
    );

    localparam logic [127:0] L5  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] L3  = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    localparam logic [127:0] L7  = 128'h7777_7777_7777_7777_7777_7777_7777_7777;
    localparam logic [127:0] L8  = 128'h8888_1111_8888_1111_8888_1111_8888_1111;
    localparam logic [127:0] L9  = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001;
    localparam logic [127:0] A5S = {16{8'hA5}};
    localparam logic [127:0] W7  = 128'hDEAD_BEEF_0000_0007_DEAD_BEEF_0000_0007;
    localparam logic [127:0] D7  = 128'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD;
    localparam logic [127:0] D8  = 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0;
    localparam logic [127:0] W9  = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    localparam logic [127:0] B0  = 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload_a(input logic [5:0] idx, input logic [127:0] data);
        a_init_en   = 1'b1;
        a_init_addr = idx;
        a_init_data = data;
        step();
        a_init_en   = 1'b0;
    endtask

    // One transaction on A; optionally pulses init_en during the READY cycle.
    task automatic txn_a(input string tag, input logic rd, input logic wr,
                         input logic [27:0] addr, input logic [127:0] wd, input logic hold,
                         input logic init_rdy, input logic [5:0] ia, input logic [127:0] id,
                         input logic [127:0] exp_rd);
        int n;
        logic [127:0] exp;
        if (rd && !wr) sb_q.push_back(exp_rd);
        a_read  = rd;
        a_write = wr;
        a_addr  = addr;
        a_wdata = wd;
        step();
        check({tag, "_busy_after_accept"}, 128'(a_busy), 128'd1);
        check({tag, "_noready_after_accept"}, 128'(a_ready), 128'd0);
        if (!hold) begin
            a_read  = 1'b0;
            a_write = 1'b0;
            a_addr  = ~addr;
            a_wdata = ~wd;
        end
        n = 0;
        while (a_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 128'(n), 128'd4);
        check({tag, "_busy_in_ready"}, 128'(a_busy), 128'd1);
        a_read  = 1'b0;
        a_write = 1'b0;
        if (init_rdy) begin
            a_init_en   = 1'b1;
            a_init_addr = ia;
            a_init_data = id;
        end
        if (rd && !wr) begin
            check({tag, "_sb_nonempty"}, 128'(sb_q.size() != 0), 128'd1);
            if (sb_q.size() != 0) begin
                exp = sb_q.pop_front();
                check({tag, "_rdata"}, a_rdata, exp);
            end
        end
        step();
        a_init_en = 1'b0;
        check({tag, "_ready_single"}, 128'(a_ready), 128'd0);
        check({tag, "_idle_busy"}, 128'(a_busy), 128'd0);
    endtask

    initial begin
        int pulses;
        logic prev;
        proc_reset = 1'b1;
        a_read = 1'b0; a_write = 1'b0; a_addr = 28'h0; a_wdata = 128'h0;
        a_init_en = 1'b0; a_init_addr = 6'h0; a_init_data = 128'h0;
        b_read = 1'b0; b_write = 1'b0; b_addr = 28'h0; b_wdata = 128'h0;
        b_init_en = 1'b0; b_init_addr = 6'h0; b_init_data = 128'h0;
        step();
        step();
        check("rst_a_ready", 128'(a_ready), 128'd0);
        check("rst_a_busy", 128'(a_busy), 128'd0);
        check("rst_a_rdata", a_rdata, 128'h0);
        check("rst_b_ready", 128'(b_ready), 128'd0);
        check("rst_b_rdata", b_rdata, 128'h0);
        proc_reset = 1'b0;

        preload_a(6'd5, L5);
        preload_a(6'd3, L3);
        preload_a(6'd7, L7);
        preload_a(6'd8, L8);
        preload_a(6'd9, L9);

        txn_a("rd5", 1'b1, 1'b0, 28'h5, 128'h0, 1'b0, 1'b0, 6'd0, 128'h0, L5);
        check("rd5_hold", a_rdata, L5);

        txn_a("wr45_held", 1'b0, 1'b1, 28'h45, A5S, 1'b1, 1'b0, 6'd0, 128'h0, 128'h0);
        check("wr45_rdata_kept", a_rdata, L5);
        txn_a("rd5_alias", 1'b1, 1'b0, 28'h5, 128'h0, 1'b0, 1'b0, 6'd0, 128'h0, A5S);

        txn_a("rdwr3", 1'b1, 1'b1, 28'h3, 128'h1, 1'b0, 1'b0, 6'd0, 128'h0, 128'h0);
        check("rdwr3_no_read", a_rdata, A5S);
        txn_a("rd3", 1'b1, 1'b0, 28'h3, 128'h0, 1'b0, 1'b0, 6'd0, 128'h0, 128'h1);

        // Reset in cycle 2 of a write to line 9.
        a_write = 1'b1; a_addr = 28'h9; a_wdata = W9;
        step();
        a_write = 1'b0;
        step();
        proc_reset = 1'b1;
        step();
        proc_reset = 1'b0;
        check("rstmid_ready", 128'(a_ready), 128'd0);
        check("rstmid_busy", 128'(a_busy), 128'd0);
        check("rstmid_rdata", a_rdata, 128'h0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (a_ready === 1'b1) pulses++;
        end
        check("rstmid_no_pulse", 128'(pulses), 128'd0);
        txn_a("rd9_unchanged", 1'b1, 1'b0, 28'h9, 128'h0, 1'b0, 1'b0, 6'd0, 128'h0, L9);

        txn_a("wr7_vs_init", 1'b0, 1'b1, 28'h7, W7, 1'b0, 1'b1, 6'd7, D7, 128'h0);
        txn_a("rd7", 1'b1, 1'b0, 28'h7, 128'h0, 1'b0, 1'b0, 6'd0, 128'h0, W7);

        txn_a("rd8_init_in_ready", 1'b1, 1'b0, 28'h8, 128'h0, 1'b0, 1'b1, 6'd8, D8, L8);
        txn_a("rd8_after_init", 1'b1, 1'b0, 28'h8, 128'h0, 1'b0, 1'b0, 6'd0, 128'h0, D8);

        // LATENCY=1 with a continuously held read, aliased onto line 0.
        b_init_en = 1'b1; b_init_addr = 6'd0; b_init_data = B0;
        step();
        b_init_en = 1'b0;
        b_read = 1'b1; b_addr = 28'hFFFFFC0;
        prev = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("lat1_ready_c%0d", i), 128'(b_ready), 128'((i % 2) == 0));
            check($sformatf("lat1_noconsec_c%0d", i), 128'(prev && b_ready), 128'd0);
            if (b_ready === 1'b1) begin
                pulses++;
                check($sformatf("lat1_rdata_c%0d", i), b_rdata, B0);
            end
            prev = b_ready;
        end
        b_read = 1'b0;
        check("lat1_pulses", 128'(pulses), 128'd6);
        check("sb_drained", 128'(sb_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_line_responder.md
MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

Interface
REQ-001 Parameter LATENCY, default 4, means the number of clock edges from request acceptance to mem_ready; legal range 1..15.
REQ-002 Parameter DEPTH_LOG2, default 6, means log2 of the number of 128-bit lines stored.
REQ-003 The clock and reset SHALL be: one clock, clk; reset proc_reset, synchronous, active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 proc_reset  input  1  synchronous active-high reset.
REQ-006 mem_read  input  1  line read request from the cache miss path.
REQ-007 mem_write  input  1  line write-back request from the cache.
REQ-008 mem_addr  input  28  line address (byte address bits 31:4).
REQ-009 mem_wdata  input  128  write-back line data.
REQ-010 mem_rdata  output  128  read line data, valid while mem_ready=1 after a read.
REQ-011 mem_ready  output  1  one-cycle completion pulse.
REQ-012 init_en  input  1  backdoor line preload strobe.
REQ-013 init_addr  input  DEPTH_LOG2  backdoor line index.
REQ-014 init_data  input  128  backdoor line data.
REQ-015 busy  output  1  high in BUSY and READY states.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY and READY.
REQ-017 In IDLE, if mem_read|mem_write is sampled at edge k, the block SHALL latch the op, mem_addr[DEPTH_LOG2-1:0] and mem_wdata, load the counter with LATENCY-1, and enter BUSY.
REQ-018 When mem_read and mem_write are both 1 at acceptance, write SHALL take priority and no read is performed.
REQ-019 Address bits above DEPTH_LOG2-1 SHALL be ignored; aliasing is intended.
REQ-020 In BUSY, the counter SHALL decrement each edge. At counter 0 the block SHALL enter READY, so that mem_ready=1 in the cycle after edge k+LATENCY.
REQ-021 With LATENCY=1, BUSY SHALL last zero cycles: edge k goes directly to READY.
REQ-022 In READY, mem_ready SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-023 For a read, mem_rdata SHALL equal the stored line at the latched index during the READY cycle.
REQ-024 For a write, the latched data SHALL be committed to the line array at the edge ending READY.
REQ-025 mem_rdata SHALL hold its last read value outside READY cycles.
REQ-026 Requests in BUSY and READY SHALL be ignored. Dropping or changing requests mid-transaction SHALL NOT abort or alter it.
REQ-027 A request still asserted in the cycle after READY (IDLE) SHALL be accepted as a new transaction; the requester deasserts in that cycle after seeing mem_ready.
REQ-028 init_en SHALL write init_data to init_addr at the clock edge in any state.
REQ-029 If init_en and a write commit target the same index on the same edge, the write commit SHALL win.
REQ-030 A read whose READY cycle coincides with init_en to the same index SHALL return the pre-edge contents.

Reset
REQ-031 On proc_reset=1 at an edge, the FSM SHALL enter IDLE, with mem_ready=0, busy=0, mem_rdata=0 and the counter at 0.
REQ-032 Reset during BUSY or READY SHALL abort the transaction with no array write and no mem_ready pulse.
REQ-033 Line array contents SHALL NOT be cleared by reset.

Structure
REQ-034 Package mem_resp_pkg SHALL hold the state enum, LINE_W=128, ADDR_W=28 and the default LATENCY and DEPTH_LOG2.
REQ-035 Sub-module mem_line_array SHALL hold 2^DEPTH_LOG2 x 128-bit storage with one combinational read port and two prioritized write ports (commit, init).

Verification
REQ-036 Scenario: preload line 5 = 128'h0123...CDEF; pulse mem_read, addr=28'h5 at edge 0 -> mem_ready=1 only in cycle 4, with mem_rdata=preload value.
REQ-037 Scenario: mem_write addr=28'h45, wdata=128'hA5 repeated, held high -> single ready pulse; the next read of addr 28'h5 returns 128'hA5 repeated (aliasing).
REQ-038 Scenario: mem_read=mem_write=1 at addr 3 with wdata=128'h1 -> line 3 becomes 128'h1.
REQ-039 Scenario: mem_read held continuously with LATENCY=1 -> ready pulses every 2 cycles, never on consecutive cycles.
REQ-040 Scenario: proc_reset asserted in cycle 2 of a write -> no mem_ready, line unchanged, busy=0 and mem_rdata=0 the next cycle.
REQ-041 Scenario: init_en to index 7 on the commit edge of a write to index 7 -> line 7 holds the write data.
